stopwatch_input_ctrl: RTL and testbench
=======================================

STOPWATCH_INPUT_CTRL -- requirements
Module: stopwatch_input_ctrl

Interface
REQ-001 Parameter DEBOUNCE_N, default 4: consecutive equal samples required before a debounced level changes; legal range 2..15.
REQ-002 clk  input  1  system clock, all state on rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-low (rst=0 resets).
REQ-004 sample_en  input  1  one-cycle debounce sample strobe, from the clock divider's fast tick.
REQ-005 but0  input  1  raw clear button, asynchronous to clk, 1 = pressed.
REQ-006 but1  input  1  raw pause button, asynchronous to clk, 1 = pressed.
REQ-007 sw0  input  1  raw adjust-mode switch, 1 = adjust.
REQ-008 sw1  input  1  raw adjust-field switch, 0 = minutes, 1 = seconds.
REQ-009 clr_pulse  output  1  one-cycle pulse per debounced but0 press.
REQ-010 paused  output  1  1 = counter frozen.
REQ-011 adj_mode  output  1  debounced sw0.
REQ-012 adj_sel  output  1  debounced sw1.

Function
REQ-013 Each raw input passes through its own 2-flop synchronizer before any other logic; synchronizer flops reset to 0.
REQ-014 Each synchronized input has its own debouncer: stored level L, counter C of 4 bits.
REQ-015 Debouncer updates only in cycles where sample_en=1; when sample_en=0, L and C hold.
REQ-016 On a sample where sync input equals L: C clears to 0.
REQ-017 On a sample where sync input differs from L: C increments; when incremented value reaches DEBOUNCE_N, L flips and C clears in the same cycle.
REQ-018 Debounced level changes no sooner than DEBOUNCE_N sample strobes after a stable raw change, plus 2 clk of synchronizer latency.
REQ-019 A glitch shorter than DEBOUNCE_N samples never changes L.
REQ-020 Rising edges of debounced but0/but1 detected by comparing L against a one-cycle-delayed copy; edge is a single-cycle pulse.
REQ-021 clr_pulse = rising edge of debounced but0, registered, asserted exactly one clk; holding the button never produces a second pulse.
REQ-022 Pause FSM, two states: RUN (paused=0), HOLD (paused=1); paused is a registered state decode.
REQ-023 RUN -> HOLD on but1 debounced rising edge; HOLD -> RUN on but1 debounced rising edge.
REQ-024 Any state -> RUN on but0 debounced rising edge; if but0 and but1 edges fall in the same cycle, clear wins and state is RUN.
REQ-025 adj_mode=1 forces paused=1 (combined output: state==HOLD or adj_mode); FSM state itself is unchanged by adj_mode.
REQ-026 but1 edges while adj_mode=1 are ignored (FSM holds).
REQ-027 adj_mode and adj_sel are debounced sw0/sw1 levels, registered, no edge logic.
REQ-028 Outputs change only on rising clk or on reset assertion; no combinational path from raw inputs to outputs.

Reset
REQ-029 rst=0 asynchronously forces: synchronizers, L, C, edge-delay flops all 0; FSM RUN; clr_pulse=0, paused=0, adj_mode=0, adj_sel=0.
REQ-030 Reset mid-debounce discards partial counts; after release, a button held across reset is debounced afresh and produces one edge after DEBOUNCE_N samples.
REQ-031 Reset release is synchronous in effect: first state update is the first rising clk with rst=1.

Verification
REQ-032 DEBOUNCE_N=4, sample_en every 8 clk; but1 held high 10 samples -> paused 0->1 exactly once, after 4th sample following sync delay; release then re-press -> paused 1->0.
REQ-033 but1 pulses high for 3 samples then low -> paused stays 0, no change in any output.
REQ-034 paused=1; but0 and but1 stable-high on identical cycles -> clr_pulse high exactly 1 clk, paused=0 after.
REQ-035 sw0=1 debounced -> paused=1, adj_mode=1; but1 press -> FSM unchanged; sw0=0 -> paused returns to 0.
REQ-036 but0 held 50 samples -> exactly one clr_pulse of width 1 clk.
REQ-037 rst=0 asserted while but1 counter at 3 -> all outputs 0 immediately (async); release with but1 still high -> paused=1 after 4 further samples.

Source files
------------

// File: rtl/stopwatch_input_ctrl.sv
// Input front end for the stopwatch: synchronizes and debounces two buttons and two switches,
// produces the clear pulse, and runs the pause/run state machine.
module stopwatch_input_ctrl #(
    parameter int unsigned DEBOUNCE_N = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic sample_en,
    input  logic but0,
    input  logic but1,
    input  logic sw0,
    input  logic sw1,
    output logic clr_pulse,
    output logic paused,
    output logic adj_mode,
    output logic adj_sel
);

    localparam int unsigned NumIn = 4;
    localparam logic [3:0] DebN = 4'(DEBOUNCE_N);

    // Channel order: 0 = but0 (clear), 1 = but1 (pause), 2 = sw0 (adjust), 3 = sw1 (field)
    localparam int unsigned ChClr = 0;
    localparam int unsigned ChPause = 1;
    localparam int unsigned ChAdj = 2;
    localparam int unsigned ChSel = 3;

    typedef enum logic {
        StRun,
        StHold
    } state_e;

    logic [NumIn-1:0] raw;
    logic [NumIn-1:0] sync1_q;
    logic [NumIn-1:0] sync2_q;
    logic [NumIn-1:0] level_q;
    logic [NumIn-1:0] level_d;
    logic [3:0]       cnt_q [NumIn];
    logic [3:0]       cnt_d [NumIn];
    logic [1:0]       level_dly_q;
    logic             clr_edge;
    logic             pause_edge;
    state_e           state_q;
    state_e           state_d;
    logic             clr_pulse_q;
    logic             paused_q;
    logic             adj_mode_q;
    logic             adj_sel_q;

    assign raw = {sw1, sw0, but1, but0};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    // Debouncers: a level flips only after DEBOUNCE_N consecutive differing samples.
    always_comb begin
        level_d = level_q;
        for (int i = 0; i < NumIn; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sample_en) begin
                if (sync2_q[i] == level_q[i]) begin
                    cnt_d[i] = 4'd0;
                end else if (cnt_q[i] + 4'd1 == DebN) begin
                    level_d[i] = ~level_q[i];
                    cnt_d[i]   = 4'd0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level_q <= '0;
            for (int i = 0; i < NumIn; i++) begin
                cnt_q[i] <= 4'd0;
            end
        end else begin
            level_q <= level_d;
            for (int i = 0; i < NumIn; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level_dly_q <= 2'b00;
        end else begin
            level_dly_q <= level_q[ChPause:ChClr];
        end
    end

    assign clr_edge   = level_q[ChClr] & ~level_dly_q[ChClr];
    assign pause_edge = level_q[ChPause] & ~level_dly_q[ChPause];

    // Clear takes priority; pause toggles are ignored while in adjust mode.
    always_comb begin
        state_d = state_q;
        if (clr_edge) begin
            state_d = StRun;
        end else if (pause_edge && !adj_mode_q) begin
            unique case (state_q)
                StRun:   state_d = StHold;
                StHold:  state_d = StRun;
                default: state_d = StRun;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clr_pulse_q <= 1'b0;
            paused_q    <= 1'b0;
            adj_mode_q  <= 1'b0;
            adj_sel_q   <= 1'b0;
        end else begin
            clr_pulse_q <= clr_edge;
            paused_q    <= (state_d == StHold) | level_q[ChAdj];
            adj_mode_q  <= level_q[ChAdj];
            adj_sel_q   <= level_q[ChSel];
        end
    end

    assign clr_pulse = clr_pulse_q;
    assign paused    = paused_q;
    assign adj_mode  = adj_mode_q;
    assign adj_sel   = adj_sel_q;

endmodule

// File: tb/tb_stopwatch_input_ctrl.sv
// Scoreboard bench: each scenario queues the output changes it expects; a negedge monitor
// pops and checks every observed output transition against the queue.
module tb_stopwatch_input_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic sample_en;
    logic but0 = 1'b0;
    logic but1 = 1'b0;
    logic sw0 = 1'b0;
    logic sw1 = 1'b0;
    logic clr_pulse;
    logic paused;
    logic adj_mode;
    logic adj_sel;

    int cyc = 0;
    int total = 0;
    int bad = 0;

    typedef struct {
        int   sig;
        logic val;
        int   lo;
        int   hi;
    } ev_t;

    ev_t   q[$];
    ev_t   mon_e;
    logic  mon_en = 1'b0;
    logic [3:0] prev = 4'b0000;
    logic [3:0] cur;
    int    rise_cyc = 0;
    string names[4] = '{"clr_pulse", "paused", "adj_mode", "adj_sel"};

    stopwatch_input_ctrl #(
        .DEBOUNCE_N(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sample_en(sample_en),
        .but0     (but0),
        .but1     (but1),
        .sw0      (sw0),
        .sw1      (sw1),
        .clr_pulse(clr_pulse),
        .paused   (paused),
        .adj_mode (adj_mode),
        .adj_sel  (adj_sel)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // Strobe seen by the posedge that moves cyc onto a multiple of 8
    assign sample_en = (cyc % 8 == 7);
    assign cur = {adj_sel, adj_mode, paused, clr_pulse};

    always @(negedge clk) begin
        if (!mon_en) begin
            prev = cur;
        end else begin
            for (int s = 0; s < 4; s++) begin
                if (cur[s] !== prev[s]) begin
                    total++;
                    if (q.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_change: %s went to %b at cycle %0d, required no change",
                                 names[s], cur[s], cyc);
                    end else begin
                        mon_e = q.pop_front();
                        if (mon_e.sig != s || mon_e.val !== cur[s] || cyc < mon_e.lo ||
                            cyc > mon_e.hi) begin
                            bad++;
                            $display("FAIL event: got %s=%b at cycle %0d, required %s=%b in cycles %0d..%0d",
                                     names[s], cur[s], cyc, names[mon_e.sig], mon_e.val,
                                     mon_e.lo, mon_e.hi);
                        end
                    end
                    if (s == 0) begin
                        if (cur[0] === 1'b1) begin
                            rise_cyc = cyc;
                        end else begin
                            total++;
                            if (cyc - rise_cyc !== 1) begin
                                bad++;
                                $display("FAIL clr_width: pulse width %0d clk, required 1",
                                         cyc - rise_cyc);
                            end
                        end
                    end
                end
            end
            prev = cur;
        end
    end

    task automatic push(input int s, input logic v, input int t);
        q.push_back(ev_t'{s, v, t - 1, t + 1});
    endtask

    // Returns at the negedge right after a sample strobe has been consumed
    task automatic wait_strobe();
        @(negedge clk);
        while (cyc % 8 != 0) @(negedge clk);
    endtask

    task automatic wait_samples(input int n);
        repeat (n * 8) @(negedge clk);
    endtask

    task automatic drain(input string tag);
        repeat (4) @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL %s_pending: %0d expected events never seen, required 0", tag, q.size());
            q.delete();
        end
    endtask

    task automatic test_reset();
        #1;
        total += 4;
        if (clr_pulse !== 1'b0) begin bad++; $display("FAIL reset_clr: got %b required 0", clr_pulse); end
        if (paused !== 1'b0) begin bad++; $display("FAIL reset_paused: got %b required 0", paused); end
        if (adj_mode !== 1'b0) begin bad++; $display("FAIL reset_adj_mode: got %b required 0", adj_mode); end
        if (adj_sel !== 1'b0) begin bad++; $display("FAIL reset_adj_sel: got %b required 0", adj_sel); end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        mon_en = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_pause_toggle();
        int t;
        wait_strobe();
        t = cyc;
        but1 = 1'b1;
        push(1, 1'b1, t + 33);
        wait_samples(10);
        but1 = 1'b0;
        wait_samples(6);
        drain("press1");
        wait_strobe();
        t = cyc;
        but1 = 1'b1;
        push(1, 1'b0, t + 33);
        wait_samples(6);
        but1 = 1'b0;
        wait_samples(6);
        drain("press2");
    endtask

    task automatic test_glitch();
        wait_strobe();
        but1 = 1'b1;
        wait_samples(3);
        but1 = 1'b0;
        wait_samples(6);
        drain("glitch");
        total++;
        if (paused !== 1'b0) begin bad++; $display("FAIL glitch_paused: got %b required 0", paused); end
    endtask

    task automatic test_clear_wins();
        int t;
        wait_strobe();
        t = cyc;
        but1 = 1'b1;
        push(1, 1'b1, t + 33);
        wait_samples(5);
        but1 = 1'b0;
        wait_samples(6);
        drain("hold_setup");
        wait_strobe();
        t = cyc;
        but0 = 1'b1;
        but1 = 1'b1;
        push(0, 1'b1, t + 33);
        push(1, 1'b0, t + 33);
        push(0, 1'b0, t + 34);
        wait_samples(6);
        but0 = 1'b0;
        but1 = 1'b0;
        wait_samples(6);
        drain("clear_wins");
    endtask

    task automatic test_adjust();
        int t;
        wait_strobe();
        t = cyc;
        sw1 = 1'b1;
        push(3, 1'b1, t + 33);
        wait_samples(6);
        drain("adj_sel");
        wait_strobe();
        t = cyc;
        sw0 = 1'b1;
        push(1, 1'b1, t + 33);
        push(2, 1'b1, t + 33);
        wait_samples(6);
        drain("adj_on");
        wait_strobe();
        but1 = 1'b1;
        wait_samples(6);
        but1 = 1'b0;
        wait_samples(6);
        drain("adj_pause_ignored");
        wait_strobe();
        t = cyc;
        sw0 = 1'b0;
        push(1, 1'b0, t + 33);
        push(2, 1'b0, t + 33);
        wait_samples(6);
        drain("adj_off");
    endtask

    task automatic test_hold_clear();
        int t;
        wait_strobe();
        t = cyc;
        but0 = 1'b1;
        push(0, 1'b1, t + 33);
        push(0, 1'b0, t + 34);
        wait_samples(50);
        but0 = 1'b0;
        wait_samples(6);
        drain("hold_clear");
    endtask

    task automatic test_reset_mid();
        int t;
        wait_strobe();
        t = cyc;
        but1 = 1'b1;
        // Three strobes consumed: pause debounce counter is at 3
        repeat (28) @(negedge clk);
        mon_en = 1'b0;
        rst = 1'b0;
        #1;
        total += 4;
        if (clr_pulse !== 1'b0) begin bad++; $display("FAIL rst_mid_clr: got %b required 0", clr_pulse); end
        if (paused !== 1'b0) begin bad++; $display("FAIL rst_mid_paused: got %b required 0", paused); end
        if (adj_mode !== 1'b0) begin bad++; $display("FAIL rst_mid_adj_mode: got %b required 0", adj_mode); end
        if (adj_sel !== 1'b0) begin bad++; $display("FAIL rst_mid_adj_sel: got %b required 0", adj_sel); end
        wait_strobe();
        rst = 1'b1;
        t = cyc;
        mon_en = 1'b1;
        push(1, 1'b1, t + 33);
        push(3, 1'b1, t + 33);
        wait_samples(6);
        drain("rst_release");
        wait_strobe();
        t = cyc;
        but1 = 1'b0;
        sw1 = 1'b0;
        push(3, 1'b0, t + 33);
        wait_samples(6);
        drain("rst_tail");
    endtask

    initial begin
        test_reset();
        test_pause_toggle();
        test_glitch();
        test_clear_wins();
        test_adjust();
        test_hold_clear();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
